channel_rr_arbiter: RTL
=======================

# channel_rr_arbiter

Round-robin arbiter that shares one downstream valid/ready channel among NUM_REQ requesters, holding the grant for a whole burst (terminated by `last`). It sits in the interconnect in front of each shared slave channel, for example AW/W or AR. The granted requester's beats go to the shared channel through a fully-registered skid buffer. Each beat carries the requester index so that downstream logic can route responses.

## Interface
- NUM_REQ, 4: number of requesters, ≥1.
- DATA_WIDTH, 32: payload width per beat.
- ID_W, derived: $clog2(NUM_REQ), minimum 1.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_data_i  in  NUM_REQ*DATA_WIDTH  packed payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  in  NUM_REQ  final beat of a burst, per requester.
- req_valid_i  in  NUM_REQ  beat valid, per requester.
- req_ready_o  out  NUM_REQ  beat accepted, per requester.
- fwd_data_o  out  DATA_WIDTH  shared-channel payload.
- fwd_last_o  out  1  shared-channel last.
- fwd_id_o  out  ID_W  index of the requester that owns the beat.
- fwd_valid_o  out  1  shared-channel valid.
- fwd_ready_i  in  1  shared-channel ready.

## Operation
- The FSM has two states, IDLE and LOCKED. The pointer last_grant_q (ID_W bits) records the most recent winner.
- IDLE:
  - req_ready_o = 0.
  - If any req_valid_i is high, the winner is the first set valid bit searched circularly from last_grant_q+1, wrapping from NUM_REQ-1 to 0.
  - The winner is stored in grant_q and the FSM moves to LOCKED on the next edge.
  - With no valid request, the FSM stays in IDLE.
- LOCKED:
  - req_ready_o[grant_q] = skid bwd_ready. All other ready bits are 0.
  - An accepted beat is {grant_q, req_last_i[grant_q], req_data_i slice} pushed into the skid.
  - An accepted beat with last=1 moves the FSM to IDLE and sets last_grant_q = grant_q.
  - Beats with last=0 keep the FSM in LOCKED.
- The grant never changes mid-burst. If the owner drops valid mid-burst, the FSM stays LOCKED and waits.
- Requests from other requesters that arrive during LOCKED wait for the next arbitration.
- NUM_REQ=1 degenerates to a pass-through with one bubble between bursts.
- Outputs only change on the skid side and obey valid/ready: once fwd_valid_o is high, data, last and id are stable until fwd_ready_i.

## Timing
- Reset values:
  - State = IDLE.
  - last_grant_q = NUM_REQ-1, so requester 0 has first priority.
  - grant_q = 0.
  - req_ready_o = 0.
  - fwd_valid_o = 0.
  - fwd_data_o, fwd_last_o and fwd_id_o are don't-care until the first valid.
- Arbitration latency:
  - A valid request is seen in IDLE at cycle 0.
  - Cycle 1: LOCKED, and req_ready_o is high if the skid is not full.
  - The first beat is accepted at cycle 1 and appears on fwd_valid_o at cycle 2.
- Throughput is 1 beat/cycle within a burst while fwd_ready_i stays high. There is exactly one IDLE cycle between consecutive bursts.
- Skid: a beat accepted at cycle n is visible at cycle n+1. One stalled beat is absorbed, so req_ready_o falls one cycle after fwd_ready_i falls.
- Simultaneous events:
  - A last beat accepted in the same cycle as a fwd handshake completes both.
  - The IDLE arbitration in the following cycle uses the updated last_grant_q.
- Reset mid-burst aborts immediately:
  - The burst and the skid contents are discarded.
  - The pointer returns to its reset value and fwd_valid_o is 0 in the next cycle.

## Structure
- Shared package holds:
  - The FSM state localparams IDLE=1'b0 and LOCKED=1'b1.
  - A clog2-min-1 helper function for ID_W.
- Arbiter logic (FSM, rotating priority search, grant/pointer registers) lives in this module.
- Sub-module: one skid_buffer instance with SBUF_TYPE=0 and DATA_WIDTH = DATA_WIDTH+1+ID_W, carrying {id, last, data}.

## Test plan
- Reset, then req_valid_i=4'b0101 with single-beat bursts held and fwd_ready_i=1 → grants in order 0,2,0,2 on fwd_id_o, one bubble cycle between beats, first fwd_valid_o at cycle 2.
- All four requesters hold valid with 1-beat bursts → fwd_id_o sequence 0,1,2,3,0; no requester is served twice before the others.
- Requester 1 sends a 4-beat burst (data 0x10..0x13, last on 0x13) while requester 3 is valid → all four beats carry id 1 consecutively, then id 3; req_ready_o[3]=0 throughout.
- During the burst, fwd_ready_i=0 for 3 cycles → fwd_data_o is held stable, req_ready_o[1] falls one cycle later, no beat is lost or duplicated, and the order is preserved.
- rst_n=0 for 1 cycle after beat 2 of a 4-beat burst from requester 2 → fwd_valid_o=0 and req_ready_o=0 the next cycle; the next request from requester 0 wins first.
- NUM_REQ=1 build, back-to-back 2-beat bursts → output beats match the input order, with one idle cycle between bursts.

Source files
------------

// File: rtl/channel_rr_arbiter_pkg.sv
// channel_rr_arbiter_pkg: FSM state encodings and ID-width helper shared by the arbiter slice.
package channel_rr_arbiter_pkg;
  localparam logic IDLE   = 1'b0;
  localparam logic LOCKED = 1'b1;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/channel_rr_arbiter_skid_buffer.sv
// skid_buffer: registered valid/ready stage; type 0 is a full skid, other types a plain pipe register.
module skid_buffer #(
  parameter int SBUF_TYPE  = 0,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] bwd_data_i,
  input  logic                  bwd_valid_i,
  output logic                  bwd_ready_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic                  fwd_valid_o,
  input  logic                  fwd_ready_i
);
  generate
    if (SBUF_TYPE == 0) begin : g_full
      logic                  r_m_valid, r_s_valid;
      logic [DATA_WIDTH-1:0] r_m_data, r_s_data;
      logic                  w_load;
      assign w_load      = ~r_m_valid | fwd_ready_i;
      assign bwd_ready_o = ~r_s_valid;
      assign fwd_valid_o = r_m_valid;
      assign fwd_data_o  = r_m_data;
      // The skid slot only fills when the output register is stalled, so ready is purely registered.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_m_valid <= 1'b0;
          r_s_valid <= 1'b0;
        end else if (w_load) begin
          r_m_valid <= r_s_valid | bwd_valid_i;
          r_s_valid <= 1'b0;
        end else if (bwd_valid_i & ~r_s_valid) begin
          r_s_valid <= 1'b1;
        end
      end
      always_ff @(posedge clk) begin
        if (w_load) r_m_data <= r_s_valid ? r_s_data : bwd_data_i;
        if (~w_load & ~r_s_valid) r_s_data <= bwd_data_i;
      end
    end else begin : g_pipe
      logic                  r_valid;
      logic [DATA_WIDTH-1:0] r_data;
      assign bwd_ready_o = ~r_valid | fwd_ready_i;
      assign fwd_valid_o = r_valid;
      assign fwd_data_o  = r_data;
      always_ff @(posedge clk) begin
        if (!rst_n) r_valid <= 1'b0;
        else if (bwd_ready_o) r_valid <= bwd_valid_i;
      end
      always_ff @(posedge clk) begin
        if (bwd_ready_o) r_data <= bwd_data_i;
      end
    end
  endgenerate
endmodule

// File: rtl/channel_rr_arbiter.sv
// channel_rr_arbiter: round-robin, burst-locked arbiter sharing one valid/ready channel among NUM_REQ requesters.
module channel_rr_arbiter
  import channel_rr_arbiter_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 32,
  localparam int ID_W       = clog2_min1(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         fwd_data_o,
  output logic                          fwd_last_o,
  output logic [ID_W-1:0]               fwd_id_o,
  output logic                          fwd_valid_o,
  input  logic                          fwd_ready_i
);
  localparam int SW = DATA_WIDTH + 1 + ID_W;
  logic                  r_state;
  logic [ID_W-1:0]       r_grant, r_last_grant, w_winner;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last, w_sel_valid, w_bwd_valid, w_bwd_ready, w_push;
  logic [SW-1:0]         w_fwd;
  // Descending scan so the closest requester after the last winner is assigned last and wins.
  always_comb begin
    w_winner = r_last_grant;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid_i[(int'(r_last_grant) + k) % NUM_REQ]) w_winner = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
    end
  end
  always_comb begin
    w_sel_data  = '0;
    w_sel_last  = 1'b0;
    w_sel_valid = 1'b0;
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant == ID_W'(k)) begin
        w_sel_data     = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel_last     = req_last_i[k];
        w_sel_valid    = req_valid_i[k];
        req_ready_o[k] = (r_state == LOCKED) & w_bwd_ready;
      end
    end
  end
  assign w_bwd_valid = (r_state == LOCKED) & w_sel_valid;
  assign w_push      = w_bwd_valid & w_bwd_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
    end else if (r_state == IDLE) begin
      if (|req_valid_i) begin
        r_grant <= w_winner;
        r_state <= LOCKED;
      end
    end else if (w_push & w_sel_last) begin
      r_state      <= IDLE;
      r_last_grant <= r_grant;
    end
  end
  skid_buffer #(.SBUF_TYPE(0), .DATA_WIDTH(SW)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .bwd_data_i  ({r_grant, w_sel_last, w_sel_data}),
    .bwd_valid_i (w_bwd_valid),
    .bwd_ready_o (w_bwd_ready),
    .fwd_data_o  (w_fwd),
    .fwd_valid_o (fwd_valid_o),
    .fwd_ready_i (fwd_ready_i)
  );
  assign {fwd_id_o, fwd_last_o, fwd_data_o} = w_fwd;
endmodule
